cfg_seq: RTL
============

CFG_SEQ -- requirements
Module: cfg_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 7, register-file address width.
- DATA_WIDTH, 32, write data width.
- TAPS, 72, number of fractional-decimator coefficient addresses.
- NUM_DENUM, 5, number of IIR coefficient addresses.
- TMO, 4, maximum ACCESS cycles allowed without PREADY.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- START, in, 1, single-cycle pulse that launches a load.
- BASE_ADDR, in, ADDR_WIDTH, first target address.
- COUNT, in, ADDR_WIDTH, number of words to write.
- CFG_DATA, in, DATA_WIDTH, coefficient stream data.
- CFG_VLD, in, 1, stream valid.
- CFG_RDY, out, 1, stream ready.
- PWRITE, out, 1, register-file write strobe.
- PENABLE, out, 1, access phase.
- DATA_ADDR, out, ADDR_WIDTH, target address.
- DATA_IN, out, DATA_WIDTH, write data.
- PREADY, in, 1, register-file completion.
- FRAC_DECI_EN, out, 1, region enable (one of five, one-hot).
- IIR_EN, out, 1, region enable.
- CIC_EN, out, 1, region enable.
- CTRL_EN, out, 1, region enable.
- FIR_EN, out, 1, region enable.
- BUSY, out, 1, load in progress.
- DONE, out, 1, one-cycle completion pulse.
- ERR, out, 1, one-cycle error pulse.

Function
REQ-004 The block SHALL be controlled by an FSM with states IDLE, WAIT_DATA, SETUP and ACCESS.
REQ-005 In IDLE, START SHALL latch BASE_ADDR into an address counter and COUNT into a remaining counter.
REQ-006 Writable range SHALL be 0 to LAST = TAPS+NUM_DENUM+6, which is 83 with default parameters; addresses above LAST are read-only status.
REQ-007 On START, if COUNT==0 the block SHALL pulse DONE on the next cycle, perform no writes and stay in IDLE.
REQ-008 On START, if BASE_ADDR+COUNT-1 > LAST (computed at ADDR_WIDTH+1 bits, no wrap) the block SHALL pulse ERR on the next cycle, perform no writes and stay in IDLE.
REQ-009 Otherwise the FSM SHALL move to WAIT_DATA with BUSY=1.
REQ-010 CFG_RDY SHALL be 1 only in WAIT_DATA.
REQ-011 In WAIT_DATA, CFG_VLD&&CFG_RDY SHALL capture CFG_DATA into DATA_IN and move the FSM to SETUP.
REQ-012 In SETUP (exactly one cycle), outputs SHALL be PWRITE=1, PENABLE=0, DATA_ADDR=address counter, and exactly one region enable high; then the FSM SHALL move to ACCESS.
REQ-013 In ACCESS, outputs SHALL be PWRITE=1 and PENABLE=1, with DATA_ADDR, DATA_IN and the enable held stable from SETUP.
REQ-014 A transfer SHALL complete in the ACCESS cycle where PREADY==1; the address counter then increments and the remaining counter decrements.
REQ-015 After a completed transfer, if the remaining count is now 0 the FSM SHALL go to IDLE with DONE pulsed in the following cycle; otherwise it SHALL return to WAIT_DATA.
REQ-016 The minimum rate SHALL be 3 cycles per word (WAIT_DATA, SETUP, ACCESS) with CFG_VLD held high.
REQ-017 Region decode for DATA_ADDR a SHALL be:
- a<TAPS: FRAC_DECI_EN.
- a<TAPS+NUM_DENUM: IIR_EN.
- a==TAPS+NUM_DENUM: CIC_EN.
- a<=LAST: CTRL_EN (control bits and output select).
REQ-018 FIR_EN SHALL never be asserted by a write load.
REQ-019 All enables SHALL be 0 outside SETUP and ACCESS.
REQ-020 If ACCESS persists TMO cycles without PREADY, the block SHALL abort to IDLE, pulse ERR next cycle, drop PWRITE, PENABLE and the enables, and discard the remaining words.
REQ-021 START while BUSY SHALL be ignored.
REQ-022 CFG_VLD outside WAIT_DATA SHALL be ignored, with no capture.
REQ-023 PREADY outside ACCESS SHALL be ignored.
REQ-024 Loads crossing region boundaries SHALL switch the enable per word according to the decode.
REQ-025 DONE and ERR SHALL never be asserted in the same cycle.

Reset
REQ-026 rst=1 at any clock edge SHALL force IDLE and abandon any in-flight transfer, with no pending DONE or ERR.
REQ-027 During and after reset all outputs SHALL be 0: CFG_RDY, PWRITE, PENABLE, DATA_ADDR, DATA_IN, all enables, BUSY, DONE, ERR.
REQ-028 Reset SHALL clear the address, remaining and timeout counters.

Verification
REQ-029 START, BASE_ADDR=0, COUNT=3, CFG_VLD held 1, PREADY=1 in each ACCESS -> writes to addresses 0,1,2 with FRAC_DECI_EN only, 9 busy cycles, DONE pulses once, then BUSY=0.
REQ-030 BASE_ADDR=70, COUNT=4 -> addresses 70,71 with FRAC_DECI_EN; 72,73 with IIR_EN; DONE.
REQ-031 BASE_ADDR=80, COUNT=5 -> ERR pulse next cycle, no PWRITE asserted; COUNT=0 -> DONE next cycle, no PWRITE asserted.
REQ-032 PREADY held 0 for 4 ACCESS cycles at word 2 of 5 -> ERR pulse, IDLE, only 1 write completed, CFG_RDY=0.
REQ-033 rst=1 during ACCESS of word 1 -> next cycle all outputs 0, IDLE; a new START then runs normally.
REQ-034 START pulsed while BUSY, and CFG_VLD toggling 1-0-1 in WAIT_DATA -> second START ignored, each word captured only when VLD&&RDY, data order preserved.

Source files
------------

// File: rtl/cfg_seq.sv
// Coefficient loader: streams CFG_DATA words into consecutive register-file
// addresses over a SETUP/ACCESS write handshake, raising one region enable per word.
module cfg_seq #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 72,
  parameter int NUM_DENUM  = 5,
  parameter int TMO        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH-1:0] COUNT,
  input  logic [DATA_WIDTH-1:0] CFG_DATA,
  input  logic                  CFG_VLD,
  output logic                  CFG_RDY,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] DATA_ADDR,
  output logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  PREADY,
  output logic                  FRAC_DECI_EN,
  output logic                  IIR_EN,
  output logic                  CIC_EN,
  output logic                  CTRL_EN,
  output logic                  FIR_EN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int TW  = $clog2(TMO + 1);
  // Region bounds held one bit wider than the address so they never wrap.
  localparam logic [AW1-1:0] IIR_LO  = AW1'(TAPS);
  localparam logic [AW1-1:0] CIC_A   = AW1'(TAPS + NUM_DENUM);
  localparam logic [AW1-1:0] LAST_A  = AW1'(TAPS + NUM_DENUM + 6);
  localparam logic [TW-1:0]  TMO_LST = TW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [AW1-1:0]        end_addr, a_ext;
  logic                  phase;

  assign end_addr = {1'b0, BASE_ADDR} + {1'b0, COUNT} - AW1'(1);
  assign a_ext    = {1'b0, addr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (START) begin
        addr_d = BASE_ADDR;
        rem_d  = COUNT;
        if (COUNT == '0)             done_d  = 1'b1;
        else if (end_addr > LAST_A)  err_d   = 1'b1;
        else                         state_d = WAIT_DATA;
      end
      WAIT_DATA: if (CFG_VLD) begin
        data_d  = CFG_DATA;
        state_d = SETUP;
      end
      SETUP: begin
        tmo_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - ADDR_WIDTH'(1);
          if (rem_q == ADDR_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_DATA;
          end
        end else if (tmo_q == TMO_LST) begin
          // Stalled slave: drop the remaining words rather than hang.
          state_d = IDLE;
          rem_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign phase     = (state_q == SETUP) || (state_q == ACCESS);
  assign CFG_RDY   = (state_q == WAIT_DATA);
  assign PWRITE    = phase;
  assign PENABLE   = (state_q == ACCESS);
  assign DATA_ADDR = phase ? addr_q : '0;
  assign DATA_IN   = data_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign FIR_EN    = 1'b0;

  always_comb begin
    FRAC_DECI_EN = 1'b0;
    IIR_EN       = 1'b0;
    CIC_EN       = 1'b0;
    CTRL_EN      = 1'b0;
    if (phase) begin
      if (a_ext < IIR_LO)       FRAC_DECI_EN = 1'b1;
      else if (a_ext < CIC_A)   IIR_EN       = 1'b1;
      else if (a_ext == CIC_A)  CIC_EN       = 1'b1;
      else if (a_ext <= LAST_A) CTRL_EN      = 1'b1;
    end
  end
endmodule
